ann_coef_loader: RTL and testbench

Coefficient-fetch responder for the ANN datapath. It answers the layer controller's `request_coef` by fetching one layer's weights from external coefficient memory and writing them into the local coefficient buffer. It pulses `coef_loaded` when the layer is complete, which the controller consumes as its weights-loaded handshake. It tracks the current layer index and returns to layer 0 when `done_processing` is asserted.

---
 rtl/ann_coef_loader.sv | 183 ++++++++++++++++++
 tb/tb_ann_coef_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_coef_loader.sv
// ann_coef_loader: answers a layer controller's coefficient request by copying one layer's
// weights from external memory into the local buffer. Optional checksum: ANN_COEF_CHECKSUM_EN.
module ann_coef_loader #(
    parameter int COEF_W = 16,
    parameter int ADDR_W = 16,
    parameter int N0     = 64,
    parameter int N1     = 32,
    parameter int N2     = 16,
    parameter int N3     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_coef,
    input  logic              done_processing,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [COEF_W-1:0] mem_rdata,
    output logic              coef_wr_en,
    output logic [6:0]        coef_wr_addr,
    output logic [COEF_W-1:0] coef_wr_data,
    output logic [6:0]        coef_count,
    output logic [1:0]        layer_idx,
    output logic              busy,
    output logic              coef_loaded,
    output logic [15:0]       coef_checksum
);

    // Handshakes: request_coef is a one-cycle pulse honoured only in IDLE; mem_read is a
    // one-cycle strobe with at most one read outstanding, answered later by a one-cycle
    // mem_valid that is honoured only in WAIT_DATA; coef_loaded is a one-cycle done pulse.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [9:0] BASE1 = 10'(N0);
    localparam logic [9:0] BASE2 = 10'(N0 + N1);
    localparam logic [9:0] BASE3 = 10'(N0 + N1 + N2);

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  idx_q;
    logic [6:0]  idx_d;
    logic [1:0]  layer_q;
    logic [1:0]  layer_d;
    logic [9:0]  base_sel;
    logic [9:0]  addr_sum;
    logic [6:0]  layer_cnt;
    logic        last_word;
    logic        accept;

    logic              wr_en_q;
    logic [6:0]        wr_addr_q;
    logic [COEF_W-1:0] wr_data_q;

    // Per-layer base address and word count, decoded from the layer register only.
    always_comb begin
        base_sel  = 10'd0;
        layer_cnt = 7'(N0);
        case (layer_q)
            2'd0: begin
                base_sel  = 10'd0;
                layer_cnt = 7'(N0);
            end
            2'd1: begin
                base_sel  = BASE1;
                layer_cnt = 7'(N1);
            end
            2'd2: begin
                base_sel  = BASE2;
                layer_cnt = 7'(N2);
            end
            default: begin
                base_sel  = BASE3;
                layer_cnt = 7'(N3);
            end
        endcase
    end

    assign addr_sum  = base_sel + {3'b000, idx_q};
    assign last_word = (idx_q == (layer_cnt - 7'd1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        layer_d = layer_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request_coef) begin
                    idx_d   = 7'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (mem_valid) begin
                    accept = 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                layer_d = layer_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // End of inference wins over everything, including a response arriving this cycle.
        if (done_processing) begin
            state_d = IDLE;
            layer_d = 2'd0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 7'd0;
            layer_q   <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            layer_q <= layer_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= idx_q;
                wr_data_q <= mem_rdata;
            end
        end
    end

    // The buffer write is registered so mem_valid never reaches an output combinationally.
    assign coef_wr_en   = wr_en_q;
    assign coef_wr_addr = wr_addr_q;
    assign coef_wr_data = wr_data_q;

    assign mem_read    = (state_q == ISSUE);
    assign mem_addr    = ADDR_W'(addr_sum);
    assign busy        = (state_q != IDLE);
    assign coef_loaded = (state_q == DONE);
    assign coef_count  = layer_cnt;
    assign layer_idx   = layer_q;

`ifdef ANN_COEF_CHECKSUM_EN
    logic [15:0] rdata16;
    logic [15:0] sum_q;

    assign rdata16 = 16'(mem_rdata);

    // Accumulates at acceptance so the total is complete in the coef_loaded cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 16'd0;
        end else if (state_q == ISSUE && idx_q == 7'd0) begin
            sum_q <= 16'd0;
        end else if (accept) begin
            sum_q <= sum_q + rdata16;
        end
    end

    assign coef_checksum = sum_q;
`else
    assign coef_checksum = 16'd0;
`endif

endmodule

// File: tb/tb_ann_coef_loader.sv
// Scoreboard bench for ann_coef_loader: a behavioural memory and per-layer load model queue
// the expected buffer writes and read addresses; independent monitors pop and compare.
module tb_ann_coef_loader;

    localparam int COEF_W = 16;
    localparam int ADDR_W = 16;
    localparam int EW     = 7 + COEF_W;

    logic              clk;
    logic              rst;
    logic              request_coef;
    logic              done_processing;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [COEF_W-1:0] mem_rdata;
    logic              coef_wr_en;
    logic [6:0]        coef_wr_addr;
    logic [COEF_W-1:0] coef_wr_data;
    logic [6:0]        coef_count;
    logic [1:0]        layer_idx;
    logic              busy;
    logic              coef_loaded;
    logic [15:0]       coef_checksum;

    ann_coef_loader #(
        .COEF_W(COEF_W), .ADDR_W(ADDR_W), .N0(64), .N1(32), .N2(16), .N3(10)
    ) dut (
        .clk(clk), .rst(rst), .request_coef(request_coef), .done_processing(done_processing),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_count(coef_count), .layer_idx(layer_idx), .busy(busy),
        .coef_loaded(coef_loaded), .coef_checksum(coef_checksum)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    logic [EW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [COEF_W-1:0] mem_img [0:511];
    int n_vec = 0;
    int n_err = 0;
    int lat = 1;
    int model_layer = 0;
    int exp_loaded = 0;
    int loaded_cnt = 0;

    function automatic int n_of(input int layer);
        case (layer)
            0: return 64;
            1: return 32;
            2: return 16;
            default: return 10;
        endcase
    endfunction

    function automatic int base_of(input int layer);
        int s = 0;
        for (int j = 0; j < layer; j++) s += n_of(j);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- memory responder ----------------
    int                wait_cnt = 0;
    logic [ADDR_W-1:0] pend_addr;

    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        pend_addr = '0;
    end

    always @(negedge clk) begin
        if (mem_valid) begin
            mem_valid = 1'b0;
            mem_rdata = COEF_W'($urandom);
        end
        if (wait_cnt > 0) begin
            wait_cnt--;
            chk("no_reissue", 32'(mem_read), 32'd0);
            if (wait_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = mem_img[pend_addr[8:0]];
            end
        end else if (mem_read === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                flag("unexpected_read");
            end else begin
                chk("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            pend_addr = mem_addr;
            wait_cnt  = lat;
        end
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (coef_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_write");
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(coef_wr_addr), 32'(e[EW-1:COEF_W]));
                chk("wr_data", 32'(coef_wr_data), 32'(e[COEF_W-1:0]));
            end
        end
        if (coef_loaded === 1'b1) loaded_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy === 1'b0 && wait_cnt == 0 && mem_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("idle_timeout");
    endtask

    task automatic push_layer(output logic [15:0] sum);
        int n = n_of(model_layer);
        int b = base_of(model_layer);
        sum = 16'd0;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(ADDR_W'(b + i));
            exp_q.push_back({7'(i), mem_img[b + i]});
            sum = sum + 16'(mem_img[b + i]);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr_en", 32'(coef_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(coef_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(coef_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loaded", 32'(coef_loaded), 32'd0);
        chk("rst_checksum", 32'(coef_checksum), 32'd0);
        chk("rst_count", 32'(coef_count), 32'd64);
        chk("rst_layer", 32'(layer_idx), 32'd0);
    endtask

    // Full load; spam pulses request_coef while busy and in the completion cycle.
    task automatic do_load(input int l, input bit spam);
        int n;
        int t_req;
        bit got = 1'b0;
        logic [15:0] sum;
        wait_idle();
        lat = l;
        n = n_of(model_layer);
        push_layer(sum);
        exp_loaded++;
        request_coef = 1'b1;
        t_req = cyc;
        @(negedge clk);
        request_coef = 1'b0;
        chk("mem_read_T1", 32'(mem_read), 32'd1);
        chk("busy_T1", 32'(busy), 32'd1);
        for (int k = 0; k < 3000; k++) begin
            if (coef_loaded === 1'b1) begin
                got = 1'b1;
                break;
            end
            request_coef = spam && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            request_coef = 1'b0;
        end
        if (!got) begin
            flag("loaded_timeout");
        end else begin
            chk("load_latency", 32'(cyc - t_req), 32'(n * (l + 1) + 1));
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("layer_before_update", 32'(layer_idx), 32'(model_layer));
`ifdef ANN_COEF_CHECKSUM_EN
            chk("checksum", 32'(coef_checksum), 32'(sum));
`else
            chk("checksum_off", 32'(coef_checksum), 32'd0);
`endif
            request_coef = spam;
            @(negedge clk);
            request_coef = 1'b0;
            model_layer = (model_layer + 1) % 4;
            chk("idle_after_done", 32'(busy), 32'd0);
            chk("layer_after", 32'(layer_idx), 32'(model_layer));
            chk("count_after", 32'(coef_count), 32'(n_of(model_layer)));
        end
    endtask

    // Starts a load and interrupts it one cycle after the (k+1)-th read strobe.
    task automatic do_interrupt(input int l, input int k, input bit use_rst);
        int seen = 0;
        logic [15:0] sum;
        wait_idle();
        lat = l;
        push_layer(sum);
        request_coef = 1'b1;
        @(negedge clk);
        request_coef = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (mem_read === 1'b1) begin
                seen++;
                if (seen == k + 1) break;
            end
            @(negedge clk);
        end
        if (seen != k + 1) flag("interrupt_point_timeout");
        @(negedge clk);
        exp_q.delete();
        exp_addr_q.delete();
        if (use_rst) rst = 1'b1;
        else done_processing = 1'b1;
        @(negedge clk);
        if (use_rst) begin
            check_reset_outputs();
            rst = 1'b0;
        end else begin
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_layer", 32'(layer_idx), 32'd0);
            chk("abort_count", 32'(coef_count), 32'd64);
            done_processing = 1'b0;
        end
        model_layer = 0;
        repeat (l + 4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        request_coef = 1'b0;
        done_processing = 1'b0;
        for (int i = 0; i < 512; i++) mem_img[i] = COEF_W'(i);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Data equals address: four layers back to back, then wrap to layer 0.
        for (int l = 0; l < 4; l++) do_load(1, 1'b0);

        for (int i = 0; i < 512; i++) mem_img[i] = COEF_W'($urandom);
        do_load($urandom_range(1, 3), 1'b1);
        do_load(2, 1'b1);
        do_load(3, 1'b1);
        do_load($urandom_range(1, 4), 1'b0);

        do_load(1, 1'b0);
        do_interrupt(4, 2, 1'b0);
        do_load(1, 1'b0);
        do_interrupt(1, 5, 1'b1);
        do_load(1, 1'b0);

        for (int r = 0; r < 6; r++) do_load($urandom_range(1, 4), 1'($urandom_range(0, 1)));

        wait_idle();
        repeat (10) @(negedge clk);
        chk("loaded_pulses", 32'(loaded_cnt), 32'(exp_loaded));
        chk("writes_pending", 32'(exp_q.size()), 32'd0);
        chk("reads_pending", 32'(exp_addr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
